uart_tx_param: RTL and testbench

- Parametrised UART transmitter; successor to the fixed 8N1 sender plus its separate baud pulse generator.
- Merges the bit-period counter into the block.
- Adds generic data width, 1 or 2 stop bits, a valid/ready handshake and optional parity.
- Sits between the host-side byte source and the board TX pin.

---
 rtl/uart_tx_param.sv | 143 ++++++++++++++
 tb/tb_uart_tx_param.sv | 232 +++++++++++++++++++++++
 2 files changed

// File: rtl/uart_tx_param.sv
// Parametrised UART transmitter: start bit, DATA_BITS LSB-first, optional parity, STOP_BITS stop bits.
// Parity stage is compiled in only when UART_TX_PARITY_EN is defined.
module uart_tx_param #(
    parameter int DATA_BITS    = 8,
    parameter int CLKS_PER_BIT = 868,
    parameter int STOP_BITS    = 1,
    parameter int PARITY_ODD   = 0
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic [DATA_BITS-1:0] data,
    input  logic                 valid,
    output logic                 ready,
    output logic                 tx,
    output logic                 busy,
    output logic                 done
);
    localparam int BAUD_W = $clog2(CLKS_PER_BIT);
    localparam int BIT_W  = $clog2(DATA_BITS);
    localparam logic [BAUD_W-1:0] BAUD_LAST = BAUD_W'(CLKS_PER_BIT - 1);
    localparam logic [BIT_W-1:0]  DATA_LAST = BIT_W'(DATA_BITS - 1);
    localparam logic [BIT_W-1:0]  STOP_LAST = BIT_W'(STOP_BITS - 1);

    if (DATA_BITS < 5 || DATA_BITS > 9 || CLKS_PER_BIT < 2 ||
        STOP_BITS < 1 || STOP_BITS > 2 || PARITY_ODD < 0 || PARITY_ODD > 1) begin : g_bad_param
        $error("uart_tx_param: illegal parameter value");
    end

    typedef enum logic [2:0] {
        IDLE,
        START,
        DATA,
`ifdef UART_TX_PARITY_EN
        PARITY,
`endif
        STOP
    } state_t;

    state_t               state;
    logic [DATA_BITS-1:0] shreg;
    logic [BAUD_W-1:0]    baud_cnt;
    logic [BIT_W-1:0]     bit_cnt;
    logic                 baud_wrap;
`ifdef UART_TX_PARITY_EN
    logic                 par_bit;
`endif

    assign baud_wrap = (baud_cnt == BAUD_LAST);

    // tx is set on the edge that enters each bit so it is always a plain register output
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state    <= IDLE;
            shreg    <= '0;
            baud_cnt <= '0;
            bit_cnt  <= '0;
            tx       <= 1'b1;
            ready    <= 1'b1;
            busy     <= 1'b0;
            done     <= 1'b0;
`ifdef UART_TX_PARITY_EN
            par_bit  <= 1'b0;
`endif
        end else begin
            done <= 1'b0;
            case (state)
                IDLE: begin
                    if (valid && ready) begin
                        shreg    <= data;
                        baud_cnt <= '0;
                        bit_cnt  <= '0;
                        tx       <= 1'b0;
                        busy     <= 1'b1;
                        ready    <= 1'b0;
                        state    <= START;
                    end
                end
                START: begin
                    if (baud_wrap) begin
                        baud_cnt <= '0;
                        tx       <= shreg[0];
                        state    <= DATA;
`ifdef UART_TX_PARITY_EN
                        // shreg is still the unshifted latched character here
                        par_bit  <= (^shreg) ^ (PARITY_ODD != 0);
`endif
                    end else begin
                        baud_cnt <= baud_cnt + 1'b1;
                    end
                end
                DATA: begin
                    if (baud_wrap) begin
                        baud_cnt <= '0;
                        if (bit_cnt == DATA_LAST) begin
                            bit_cnt <= '0;
`ifdef UART_TX_PARITY_EN
                            tx      <= par_bit;
                            state   <= PARITY;
`else
                            tx      <= 1'b1;
                            state   <= STOP;
`endif
                        end else begin
                            bit_cnt <= bit_cnt + 1'b1;
                            shreg   <= shreg >> 1;
                            tx      <= shreg[1];
                        end
                    end else begin
                        baud_cnt <= baud_cnt + 1'b1;
                    end
                end
`ifdef UART_TX_PARITY_EN
                PARITY: begin
                    if (baud_wrap) begin
                        baud_cnt <= '0;
                        tx       <= 1'b1;
                        state    <= STOP;
                    end else begin
                        baud_cnt <= baud_cnt + 1'b1;
                    end
                end
`endif
                STOP: begin
                    if (baud_wrap) begin
                        baud_cnt <= '0;
                        if (bit_cnt == STOP_LAST) begin
                            bit_cnt <= '0;
                            busy    <= 1'b0;
                            ready   <= 1'b1;
                            done    <= 1'b1;
                            state   <= IDLE;
                        end else begin
                            bit_cnt <= bit_cnt + 1'b1;
                        end
                    end else begin
                        baud_cnt <= baud_cnt + 1'b1;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_uart_tx_param.sv
// Bench for uart_tx_param: three instances (8N1 even, 5-bit 2 stop, 8-bit odd) against a frame-level model.
// Works with or without UART_TX_PARITY_EN.
module tb_uart_tx_param;
    localparam int CPB = 4;
`ifdef UART_TX_PARITY_EN
    localparam int P = 1;
`else
    localparam int P = 0;
`endif

    logic       clk = 1'b0;
    logic       rst = 1'b0;
    logic       v0 = 1'b0, v1 = 1'b0, v2 = 1'b0;
    logic [7:0] d0 = '0, d2 = '0;
    logic [4:0] d1 = '0;
    logic [2:0] tx, ready, busy, done;

    int checks = 0;
    int failures = 0;

    always #5 clk = ~clk;

    uart_tx_param #(.DATA_BITS(8), .CLKS_PER_BIT(CPB), .STOP_BITS(1), .PARITY_ODD(0)) u_l0 (
        .clk(clk), .rst(rst), .data(d0), .valid(v0),
        .ready(ready[0]), .tx(tx[0]), .busy(busy[0]), .done(done[0]));
    uart_tx_param #(.DATA_BITS(5), .CLKS_PER_BIT(CPB), .STOP_BITS(2), .PARITY_ODD(0)) u_l1 (
        .clk(clk), .rst(rst), .data(d1), .valid(v1),
        .ready(ready[1]), .tx(tx[1]), .busy(busy[1]), .done(done[1]));
    uart_tx_param #(.DATA_BITS(8), .CLKS_PER_BIT(CPB), .STOP_BITS(1), .PARITY_ODD(1)) u_l2 (
        .clk(clk), .rst(rst), .data(d2), .valid(v2),
        .ready(ready[2]), .tx(tx[2]), .busy(busy[2]), .done(done[2]));

    task automatic check(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            failures++;
            $display("FAIL %s actual=%0d required=%0d t=%0t", name, act, exp, $time);
        end
    endtask

    // ---------------- frame-level model ----------------
    int nb [3] = '{8, 5, 8};
    int sb [3] = '{1, 2, 1};
    int po [3] = '{0, 0, 1};

    logic        m_busy [3] = '{1'b0, 1'b0, 1'b0};
    logic        m_done [3] = '{1'b0, 1'b0, 1'b0};
    int          m_pos  [3] = '{0, 0, 0};
    logic [12:0] m_frame[3];

    function automatic int flen(input int l);
        return (1 + nb[l] + P + sb[l]) * CPB;
    endfunction

    // symbol list: start, data LSB first, optional parity, then ones for stop
    function automatic logic [12:0] build(input logic [8:0] d, input int n, input int odd);
        logic [12:0] f;
        logic        p;
        f = '1;
        f[0] = 1'b0;
        p = (odd != 0);
        for (int i = 0; i < n; i++) begin
            f[1 + i] = d[i];
            p = p ^ d[i];
        end
`ifdef UART_TX_PARITY_EN
        f[1 + n] = p;
`endif
        return f;
    endfunction

    function automatic logic [8:0] lane_data(input int l);
        case (l)
            0: return {1'b0, d0};
            1: return {4'b0, d1};
            default: return {1'b0, d2};
        endcase
    endfunction

    function automatic logic lane_valid(input int l);
        case (l)
            0: return v0;
            1: return v1;
            default: return v2;
        endcase
    endfunction

    always @(posedge clk or negedge rst) begin
        for (int l = 0; l < 3; l++) begin
            if (!rst) begin
                m_busy[l] = 1'b0;
                m_done[l] = 1'b0;
                m_pos[l]  = 0;
            end else begin
                m_done[l] = 1'b0;
                if (m_busy[l]) begin
                    if (m_pos[l] == flen(l) - 1) begin
                        m_busy[l] = 1'b0;
                        m_done[l] = 1'b1;
                    end else begin
                        m_pos[l]++;
                    end
                end else if (lane_valid(l)) begin
                    m_busy[l]  = 1'b1;
                    m_pos[l]   = 0;
                    m_frame[l] = build(lane_data(l), nb[l], po[l]);
                end
            end
        end
    end

    always @(negedge clk) begin
        for (int l = 0; l < 3; l++) begin
            check($sformatf("cyc_tx%0d", l), int'(tx[l]),
                  m_busy[l] ? int'(m_frame[l][m_pos[l] / CPB]) : 1);
            check($sformatf("cyc_ready%0d", l), int'(ready[l]), int'(!m_busy[l]));
            check($sformatf("cyc_busy%0d", l), int'(busy[l]), int'(m_busy[l]));
            check($sformatf("cyc_done%0d", l), int'(done[l]), int'(m_done[l]));
        end
    end

    // ---------------- directed stimulus ----------------
`ifdef UART_TX_PARITY_EN
    localparam int NS0 = 11;
    localparam int NS1 = 9;
    logic [10:0] lit0  = {1'b1, 1'b1, 8'b01100100, 1'b0};
    logic [10:0] lit3c = {1'b1, 1'b0, 8'h3C, 1'b0};
    logic [8:0]  lit1a = {2'b11, 1'b1, 5'b10101, 1'b0};
    logic [8:0]  lit1b = {2'b11, 1'b0, 5'b01010, 1'b0};
    localparam int L0 = 44;
    localparam int PAR2 = 0;
`else
    localparam int NS0 = 10;
    localparam int NS1 = 8;
    logic [10:0] lit0  = {1'b0, 1'b1, 8'b01100100, 1'b0};
    logic [10:0] lit3c = {1'b0, 1'b1, 8'h3C, 1'b0};
    logic [8:0]  lit1a = {1'b0, 2'b11, 5'b10101, 1'b0};
    logic [8:0]  lit1b = {1'b0, 2'b11, 5'b01010, 1'b0};
    localparam int L0 = 40;
    localparam int PAR2 = 1;
`endif
    localparam int L1 = (1 + 5 + P + 2) * CPB;

    initial begin
        int rlow, dok, dbad, dcnt, idle;

        // reset and idle
        repeat (5) @(posedge clk);
        check("rst_tx", int'(tx), 7);
        check("rst_ready", int'(ready), 7);
        check("rst_busy_done", int'({busy, done}), 0);
        #2 rst = 1'b1;
        for (int c = 0; c < 20; c++) begin
            @(negedge clk);
            if (c % 5 == 0) check("idle_tx_ready", int'({tx, ready}), 63);
        end

        // 8-bit frame on lanes 0 (even) and 2 (odd)
        @(posedge clk); #2 d0 = 8'h64; d2 = 8'h64; v0 = 1'b1; v2 = 1'b1;
        @(posedge clk); #2 v0 = 1'b0; v2 = 1'b0;
        rlow = 0; dok = 0; dbad = 0;
        for (int c = 1; c <= L0 + 3; c++) begin
            @(negedge clk);
            if (!ready[0]) rlow++;
            if (done[0]) begin
                if (c == L0 + 1) dok++;
                else dbad++;
            end
            if (c % 4 == 2 && (c - 2) / 4 < NS0)
                check("f1_bit", int'(tx[0]), int'(lit0[(c - 2) / 4]));
            if (c == 9 * 4 + 2) check("f1_lane2_sym9", int'(tx[2]), PAR2);
        end
        check("f1_ready_low", rlow, L0);
        check("f1_done_cycle", dok, 1);
        check("f1_done_extra", dbad, 0);

        // two stop bits, back-to-back on lane 1
        @(posedge clk); #2 d1 = 5'h15; v1 = 1'b1;
        @(posedge clk); #2 d1 = 5'h0A;
        dcnt = 0; idle = 0;
        for (int c = 1; c <= 2 * L1 + 6; c++) begin
            @(negedge clk);
            if (done[1]) dcnt++;
            if (!busy[1] && c <= 2 * L1 + 1) idle++;
            if (c % 4 == 2 && (c - 2) / 4 < NS1)
                check("f2a_bit", int'(tx[1]), int'(lit1a[(c - 2) / 4]));
            if (c > L1 + 1 && (c - L1 - 1) % 4 == 2 && (c - L1 - 3) / 4 < NS1)
                check("f2b_bit", int'(tx[1]), int'(lit1b[(c - L1 - 3) / 4]));
            if (c == L1 + 1) begin
                check("f2_gap_tx", int'(tx[1]), 1);
                @(posedge clk); #2 v1 = 1'b0;
            end
        end
        check("f2_done_pulses", dcnt, 2);
        check("f2_idle_gap", idle, 1);

        // reset during the third data bit of lane 0
        @(posedge clk); #2 d0 = 8'hA5; v0 = 1'b1;
        @(posedge clk); #2 v0 = 1'b0;
        repeat (13) @(posedge clk);
        #2 rst = 1'b0;
        #1;
        check("mid_rst_tx", int'(tx[0]), 1);
        check("mid_rst_ready", int'(ready[0]), 1);
        check("mid_rst_busy_done", int'({busy[0], done[0]}), 0);
        repeat (2) @(posedge clk);
        #2 rst = 1'b1;
        dcnt = 0;
        for (int c = 0; c < 8; c++) begin
            @(negedge clk);
            if (done[0]) dcnt++;
        end
        check("mid_rst_no_done", dcnt, 0);

        // new frame with data toggling every clock
        @(posedge clk); #2 d0 = 8'h3C; v0 = 1'b1;
        @(posedge clk); #2 v0 = 1'b0; d0 = 8'hC3;
        dok = 0;
        for (int c = 1; c <= L0 + 2; c++) begin
            @(negedge clk);
            if (done[0] && c == L0 + 1) dok++;
            if (c % 4 == 2 && (c - 2) / 4 < NS0)
                check("f3_bit", int'(tx[0]), int'(lit3c[(c - 2) / 4]));
            @(posedge clk); #2 d0 = 8'($urandom);
        end
        check("f3_done", dok, 1);

        repeat (5) @(posedge clk);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
